program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Upstream instruction store for the state-machine CPU. It replaces the fixed ROM behind the
//  CPU's ip -> memory_ip read. It accepts a framed byte stream over a valid/ready handshake,
//  fills a MEMSIZE x WIDTH program memory and checks an 8-bit checksum. It holds the CPU in
//  reset until a good program is loaded, then releases it. It serves the CPU's combinational
//  instruction/immediate reads.
// PARAMETERS
//  MEMSIZE  16     number of program words; legal frame lengths are 1..MEMSIZE
//  WIDTH    8      word, address and stream byte width (matches CPU REGSIZE)
//  FILL     8'hF0  fill value for unloaded or out-of-range words (HLT opcode)
// PORTS
//  CLOCK       in   1      clock, rising edge
//  RESET       in   1      reset, synchronous, active-high
//  LOAD_START  in   1      single-cycle request to start a new load
//  RX_DATA     in   WIDTH  stream byte
//  RX_VALID    in   1      RX_DATA valid
//  RX_READY    out  1      loader accepts a byte this cycle
//  RD_ADDR     in   WIDTH  CPU read address (ip)
//  RD_DATA     out  WIDTH  word at RD_ADDR (memory_ip), combinational
//  CPU_RESET   out  1      reset to the CPU; high except in RUN
//  BUSY        out  1      high in LEN, DATA and CSUM
//  ERROR       out  1      high in ERR
//  LOADED_LEN  out  WIDTH  length of the last accepted frame
// BEHAVIOUR
//  Frame format: LEN byte, then LEN data bytes written to addresses 0..LEN-1, then CSUM byte.
//  Checksum: CSUM == (sum of the data bytes) mod 2^WIDTH. The LEN byte is not included.
//  Transfer: a byte moves on a rising edge when RX_VALID && RX_READY.
//   - RX_READY decodes from state only. It never depends on RX_VALID.
//   - RX_DATA is ignored when no transfer occurs.
//  States and transitions:
//   - IDLE: LOAD_START -> LEN.
//   - LEN: on transfer, if LEN is 0 or LEN > MEMSIZE -> ERR; otherwise latch count and -> DATA.
//   - DATA: on each transfer, write mem[ptr], increment ptr, add the byte to sum.
//     The transfer of byte number LEN -> CSUM.
//   - CSUM: on transfer, if match -> RUN and LOADED_LEN <= LEN; if mismatch -> ERR.
//   - RUN and ERR: LOAD_START -> LEN.
//  Entering LEN, from any state:
//   - every mem word <= FILL, ptr <= 0, sum <= 0 on the same edge;
//   - CPU_RESET is high from the next cycle;
//   - LOAD_START in LEN, DATA or CSUM restarts the frame and discards partial data.
//  Simultaneous LOAD_START and a transfer: LOAD_START wins and the byte is dropped.
//  Outputs per state:
//   - RX_READY = 1 in LEN, DATA and CSUM;
//   - CPU_RESET = 0 only in RUN, registered-state decode. It falls on the cycle after
//     the CSUM edge;
//   - ERR leaves memory contents as written and keeps CPU_RESET high.
//  Read port:
//   - RD_DATA = mem[RD_ADDR] if RD_ADDR < MEMSIZE, else FILL;
//   - it is live in all states, with no read latency;
//   - a write and a read of the same address in one cycle return the old value.
//  Arithmetic:
//   - ptr and sum are WIDTH bits; sum wraps mod 2^WIDTH;
//   - ptr never exceeds LEN, so no write goes past MEMSIZE-1.
//  Reset, including mid-load:
//   - state = IDLE, all mem = FILL, ptr = 0, sum = 0, LOADED_LEN = 0;
//   - RX_READY = 0, CPU_RESET = 1, BUSY = 0, ERROR = 0.
// TESTING
//  T1: after reset, RD_ADDR 0..20 -> RD_DATA = F0; CPU_RESET=1; RX_READY=0.
//  T2: LOAD_START, then stream 03 13 05 C0 D8 (sum 13+05+C0 = D8).
//      -> RUN; mem[0..2] = 13 05 C0; mem[3] = F0; LOADED_LEN = 3;
//      -> CPU_RESET falls 1 cycle after the D8 edge.
//  T3: stream 02 FF 02 01 (sum FF+02 = 01, wraps).
//      -> RUN. Same frame with CSUM 00 -> ERR, ERROR=1, CPU_RESET stays 1.
//  T4: LEN byte 00, and separately LEN byte 11 (17 > MEMSIZE) -> ERR right after the LEN edge;
//      no data byte is accepted.
//  T5: RX_VALID toggled every other cycle during T2's frame -> same result as T2.
//      LOAD_START coincident with the 2nd data byte -> back in LEN, mem all F0, byte dropped.
//  T6: RESET asserted mid-DATA -> IDLE, mem all F0, CPU_RESET=1.
//      From RUN, LOAD_START -> CPU_RESET=1 next cycle; a fresh load then completes normally.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream handshake between a program source and the loader.
interface program_loader_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] RX_DATA;
    logic             RX_VALID;
    logic             RX_READY;

    modport master (output RX_DATA, output RX_VALID, input RX_READY);
    modport slave  (input RX_DATA, input RX_VALID, output RX_READY);
endinterface

// File: rtl/program_loader.sv
// Program store for the state-machine CPU: loads a framed, checksummed byte stream
// into program memory and holds the CPU in reset until a good frame has landed.
//
// state  | meaning
// IDLE   | after reset, waiting for LOAD_START
// LEN    | expecting the frame length byte
// DATA   | storing data bytes at 0..LEN-1
// CSUM   | expecting the checksum byte
// RUN    | program valid, CPU released
// ERR    | bad length or checksum, CPU held
module program_loader #(
    parameter int               MEMSIZE = 16,
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] FILL    = 8'hF0
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 LOAD_START,
    program_loader_if.slave      rx,
    input  logic [WIDTH-1:0]     RD_ADDR,
    output logic [WIDTH-1:0]     RD_DATA,
    output logic                 CPU_RESET,
    output logic                 BUSY,
    output logic                 ERROR,
    output logic [WIDTH-1:0]     LOADED_LEN
);
    localparam int               AW      = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
    localparam logic [WIDTH-1:0] MEM_LIM = WIDTH'(MEMSIZE);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CSUM, S_RUN, S_ERR
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [MEMSIZE];
    logic [WIDTH-1:0] ptr_q, sum_q, len_q;
    logic             xfer, clear, wr_en, latch_len, accept;

    always_ff @(posedge CLOCK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        clear       = 1'b0;
        wr_en       = 1'b0;
        latch_len   = 1'b0;
        accept      = 1'b0;
        rx.RX_READY = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
        BUSY        = rx.RX_READY;
        CPU_RESET   = (state != S_RUN);
        ERROR       = (state == S_ERR);
        xfer        = rx.RX_VALID && rx.RX_READY;

        // A restart request outranks any byte offered on the same edge.
        if (LOAD_START) begin
            state_nxt = S_LEN;
            clear     = 1'b1;
        end else begin
            case (state)
                S_LEN: if (xfer) begin
                    if (rx.RX_DATA == '0 || rx.RX_DATA > MEM_LIM) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_DATA;
                        latch_len = 1'b1;
                    end
                end
                S_DATA: if (xfer) begin
                    wr_en = 1'b1;
                    if (ptr_q + WIDTH'(1) == len_q) state_nxt = S_CSUM;
                end
                S_CSUM: if (xfer) begin
                    if (rx.RX_DATA == sum_q) begin
                        state_nxt = S_RUN;
                        accept    = 1'b1;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET || clear) begin
            for (int i = 0; i < MEMSIZE; i++) mem[i] <= FILL;
            ptr_q <= '0;
            sum_q <= '0;
            if (RESET) begin
                len_q      <= '0;
                LOADED_LEN <= '0;
            end
        end else begin
            if (latch_len) len_q <= rx.RX_DATA;
            if (wr_en) begin
                mem[ptr_q[AW-1:0]] <= rx.RX_DATA;
                ptr_q              <= ptr_q + WIDTH'(1);
                sum_q              <= sum_q + rx.RX_DATA;
            end
            if (accept) LOADED_LEN <= len_q;
        end
    end

    // Unclocked read: a same-cycle write is seen only after the edge.
    assign RD_DATA = (RD_ADDR < MEM_LIM) ? mem[RD_ADDR[AW-1:0]] : FILL;

endmodule

// File: tb/tb_program_loader.sv
// Randomized frame traffic against a frame-level reference model of the loader.
module tb_program_loader;
    localparam int MS = 16;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       LOAD_START = 1'b0;
    logic [7:0] RD_ADDR = '0;
    logic [7:0] RD_DATA, LOADED_LEN;
    logic       CPU_RESET, BUSY, ERROR;

    program_loader_if #(.WIDTH(8)) bus ();

    program_loader dut (
        .CLOCK(CLOCK), .RESET(RESET), .LOAD_START(LOAD_START), .rx(bus),
        .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .CPU_RESET(CPU_RESET),
        .BUSY(BUSY), .ERROR(ERROR), .LOADED_LEN(LOADED_LEN)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;
    bit rand_addr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: mode plus the bytes of the frame received so far.
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_ERR = 3;
    int         m_mode = M_IDLE;
    logic [7:0] m_frame[$];
    logic [7:0] m_mem[MS];
    logic [7:0] m_loaded = '0;

    initial for (int i = 0; i < MS; i++) m_mem[i] = 8'hF0;

    always @(posedge CLOCK) begin
        if (RESET) begin
            m_mode = M_IDLE;
            m_frame.delete();
            for (int i = 0; i < MS; i++) m_mem[i] = 8'hF0;
            m_loaded = '0;
        end else if (LOAD_START) begin
            m_mode = M_LOAD;
            m_frame.delete();
            for (int i = 0; i < MS; i++) m_mem[i] = 8'hF0;
        end else if (m_mode == M_LOAD && bus.RX_VALID) begin
            int n, l, s;
            m_frame.push_back(bus.RX_DATA);
            n = m_frame.size();
            l = int'(m_frame[0]);
            if (n == 1) begin
                if (l == 0 || l > MS) m_mode = M_ERR;
            end else if (n <= l + 1) begin
                m_mem[n-2] = bus.RX_DATA;
            end else begin
                s = 0;
                for (int i = 1; i <= l; i++) s += int'(m_frame[i]);
                if ((s % 256) == int'(bus.RX_DATA)) begin
                    m_mode   = M_RUN;
                    m_loaded = m_frame[0];
                end else begin
                    m_mode = M_ERR;
                end
            end
        end
    end

    always @(negedge CLOCK) begin
        if (chk_en) begin
            chk("rx_ready",   bus.RX_READY, m_mode == M_LOAD);
            chk("busy",       BUSY,         m_mode == M_LOAD);
            chk("cpu_reset",  CPU_RESET,    m_mode != M_RUN);
            chk("error",      ERROR,        m_mode == M_ERR);
            chk("loaded_len", LOADED_LEN,   m_loaded);
            chk("rd_data",    RD_DATA,      (RD_ADDR < MS) ? m_mem[RD_ADDR] : 8'hF0);
        end
    end

    task automatic cyc();
        @(posedge CLOCK);
        #2;
        if (rand_addr) RD_ADDR = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                             : 8'($urandom_range(0, 20));
    endtask

    task automatic send(input logic [7:0] b);
        bus.RX_VALID = 1'b1;
        bus.RX_DATA  = b;
        cyc();
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = 8'($urandom);
    endtask

    task automatic start();
        LOAD_START = 1'b1;
        cyc();
        LOAD_START = 1'b0;
    endtask

    task automatic peek(input string name, input logic [7:0] a, input logic [7:0] exp);
        RD_ADDR = a;
        #1;
        chk(name, RD_DATA, exp);
    endtask

    logic [7:0] t2_exp[4];

    initial begin
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = '0;
        t2_exp = '{8'h13, 8'h05, 8'hC0, 8'hF0};

        // T1: reset state
        cyc();
        chk_en = 1;
        cyc();
        RESET = 1'b0;
        for (int a = 0; a <= 20; a++) peek("t1_fill", 8'(a), 8'hF0);
        chk("t1_cpu_reset", CPU_RESET, 1);
        chk("t1_rx_ready", bus.RX_READY, 0);

        // T2: good three-word frame
        start();
        send(8'h03); send(8'h13); send(8'h05); send(8'hC0);
        chk("t2_cpu_reset_before", CPU_RESET, 1);
        send(8'hD8);
        chk("t2_cpu_reset_after", CPU_RESET, 0);
        chk("t2_loaded_len", LOADED_LEN, 3);
        for (int a = 0; a < 4; a++) peek("t2_mem", 8'(a), t2_exp[a]);

        // T3: wrapping checksum, then the same frame with a bad checksum
        start();
        send(8'h02); send(8'hFF); send(8'h02); send(8'h01);
        chk("t3_run", CPU_RESET, 0);
        chk("t3_len", LOADED_LEN, 2);
        start();
        send(8'h02); send(8'hFF); send(8'h02); send(8'h00);
        chk("t3_error", ERROR, 1);
        chk("t3_cpu_reset", CPU_RESET, 1);
        chk("t3_len_kept", LOADED_LEN, 2);

        // T4: illegal lengths
        start();
        send(8'h00);
        chk("t4_len0_err", ERROR, 1);
        chk("t4_len0_ready", bus.RX_READY, 0);
        send(8'h13); send(8'h05);
        start();
        send(8'h11);
        chk("t4_len17_err", ERROR, 1);
        send(8'h22);
        peek("t4_mem0", 8'h00, 8'hF0);

        // T5: gapped valid, then restart colliding with a data byte
        start();
        send(8'h03); cyc(); send(8'h13); cyc(); send(8'h05); cyc(); send(8'hC0); cyc(); send(8'hD8);
        chk("t5_run", CPU_RESET, 0);
        chk("t5_len", LOADED_LEN, 3);
        peek("t5_mem2", 8'h02, 8'hC0);
        start();
        send(8'h03); send(8'h13);
        LOAD_START = 1'b1;
        send(8'h05);
        LOAD_START = 1'b0;
        chk("t5_restart_busy", BUSY, 1);
        peek("t5_restart_mem0", 8'h00, 8'hF0);
        send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC); send(8'h31);
        chk("t5_reload_run", CPU_RESET, 0);
        peek("t5_reload_mem0", 8'h00, 8'hAA);

        // T6: reset mid-data, then restart from RUN
        start();
        send(8'h03); send(8'h13); send(8'h05);
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        chk("t6_busy", BUSY, 0);
        chk("t6_cpu_reset", CPU_RESET, 1);
        chk("t6_len_cleared", LOADED_LEN, 0);
        peek("t6_mem0", 8'h00, 8'hF0);
        start();
        send(8'h01); send(8'h7E); send(8'h7E);
        chk("t6_run", CPU_RESET, 0);
        start();
        chk("t6_restart_cpu_reset", CPU_RESET, 1);
        send(8'h02); send(8'h10); send(8'h20); send(8'h30);
        chk("t6_fresh_run", CPU_RESET, 0);
        chk("t6_fresh_len", LOADED_LEN, 2);

        // Randomized frames with gaps, collisions and occasional resets
        rand_addr = 1;
        for (int f = 0; f < 80; f++) begin
            logic [7:0] fr[$];
            int len, s;
            len = $urandom_range(0, 18);
            fr.push_back(8'(len));
            s = 0;
            for (int i = 0; i < len; i++) begin
                fr.push_back(8'($urandom));
                s += int'(fr[i+1]);
            end
            fr.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(s));
            start();
            foreach (fr[i]) begin
                repeat ($urandom_range(0, 2)) cyc();
                LOAD_START = ($urandom_range(0, 60) == 0);
                RESET      = ($urandom_range(0, 120) == 0);
                send(fr[i]);
                LOAD_START = 1'b0;
                RESET      = 1'b0;
            end
            repeat ($urandom_range(1, 4)) cyc();
        end

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
